load_align_unit: RTL and testbench

Load-path counterpart to the store data filter: accepts a load request from the pipeline, issues a word-aligned read to data memory over a req/gnt/rvalid handshake, then selects the addressed byte or halfword and sign- or zero-extends it into a 32-bit result. It sits between the execute/memory stage and the data memory port. It is a single-outstanding, multi-cycle unit with misalignment detection and a response timeout.

---
 rtl/load_pkg.sv | 29 ++
 rtl/load_extract.sv | 27 ++
 rtl/load_align_unit.sv | 112 +++++++++++
 tb/tb_load_align_unit.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/load_pkg.sv
// Shared types and constants for the load alignment path.
package load_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } state_t;

   localparam logic [2:0] SZ_W  = 3'd0;
   localparam logic [2:0] SZ_B  = 3'd1;
   localparam logic [2:0] SZ_BU = 3'd2;
   localparam logic [2:0] SZ_H  = 3'd3;
   localparam logic [2:0] SZ_HU = 3'd4;

   localparam int unsigned DEFAULT_TIMEOUT = 255;

   // Priority lb > lbu > lh > lhu; nothing selected means a full word.
   function automatic logic [2:0] size_decode(input logic lb, input logic lbu,
                                              input logic lh, input logic lhu);
      if (lb)       return SZ_B;
      else if (lbu) return SZ_BU;
      else if (lh)  return SZ_H;
      else if (lhu) return SZ_HU;
      else          return SZ_W;
   endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational byte/halfword lane select with sign or zero extension.
module load_extract
   import load_pkg::*;
(
   input  logic [2:0]  size,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] rdata,
   output logic [31:0] ext_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata[{addr_lo, 3'b000} +: 8];
      half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      ext_data = rdata;
      case (size)
         SZ_B:    ext_data = {{24{byte_sel[7]}}, byte_sel};
         SZ_BU:   ext_data = {24'd0, byte_sel};
         SZ_H:    ext_data = {{16{half_sel[15]}}, half_sel};
         SZ_HU:   ext_data = {16'd0, half_sel};
         default: ext_data = rdata;
      endcase
   end

endmodule

// File: rtl/load_align_unit.sv
// Single-outstanding load unit: word-aligned memory read, lane extract, misalign/timeout faults.
module load_align_unit
   import load_pkg::*;
#(
   parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ld_valid,
   output logic        ld_ready,
   input  logic [31:0] addr,
   input  logic        lb,
   input  logic        lbu,
   input  logic        lh,
   input  logic        lhu,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic [31:0] load_data,
   output logic        load_valid,
   output logic        load_fault
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   state_t           state, next_state;
   logic [2:0]       size_q;
   logic [31:0]      addr_q;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       size_in;
   logic             misaligned;
   logic             timeout_hit;
   logic [31:0]      ext_data;

   assign size_in     = size_decode(lb, lbu, lh, lhu);
   assign misaligned  = (((size_in == SZ_H) || (size_in == SZ_HU)) && addr[0]) ||
                        ((size_in == SZ_W) && (addr[1:0] != 2'b00));
   assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
   assign mem_addr    = {addr_q[31:2], 2'b00};

   load_extract u_extract (
      .size     (size_q),
      .addr_lo  (addr_q[1:0]),
      .rdata    (mem_rdata),
      .ext_data (ext_data)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (ld_valid) next_state = misaligned ? RESP : REQ;
         REQ:  if (mem_gnt) next_state = mem_rvalid ? RESP : WAIT;
         WAIT: if (mem_rvalid || timeout_hit) next_state = RESP;
         RESP: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      ld_ready   = (state == IDLE);
      mem_req    = (state == REQ);
      load_valid = (state == RESP);
   end

   // Result registers load on the edge into RESP and then hold until the next one.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         size_q     <= SZ_W;
         addr_q     <= '0;
         cnt        <= '0;
         load_data  <= '0;
         load_fault <= 1'b0;
      end else begin
         case (state)
            IDLE: if (ld_valid) begin
               size_q <= size_in;
               addr_q <= addr;
               if (misaligned) begin
                  load_data  <= '0;
                  load_fault <= 1'b1;
               end
            end
            REQ: if (mem_gnt) begin
               cnt <= '0;
               if (mem_rvalid) begin
                  load_data  <= ext_data;
                  load_fault <= 1'b0;
               end
            end
            WAIT: begin
               cnt <= cnt + 1'b1;
               if (mem_rvalid) begin
                  load_data  <= ext_data;
                  load_fault <= 1'b0;
               end else if (timeout_hit) begin
                  load_data  <= '0;
                  load_fault <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_load_align_unit.sv
// Directed self-checking bench for load_align_unit (TIMEOUT=4).
module tb_load_align_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        ld_valid;
   logic        ld_ready;
   logic [31:0] addr;
   logic        lb, lbu, lh, lhu;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic [31:0] load_data;
   logic        load_valid;
   logic        load_fault;

   int checks   = 0;
   int failures = 0;

   load_align_unit #(.TIMEOUT(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .ld_valid   (ld_valid),
      .ld_ready   (ld_ready),
      .addr       (addr),
      .lb         (lb),
      .lbu        (lbu),
      .lh         (lh),
      .lhu        (lhu),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_gnt    (mem_gnt),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .load_data  (load_data),
      .load_valid (load_valid),
      .load_fault (load_fault)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic request(input logic [31:0] a, input logic [3:0] sel);
      ld_valid = 1'b1;
      addr     = a;
      {lb, lbu, lh, lhu} = sel;
   endtask

   task automatic drop_request;
      ld_valid = 1'b0;
      {lb, lbu, lh, lhu} = 4'b0000;
      addr = 32'hFFFF_FFFF;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      ld_valid = 1'b0; addr = '0; {lb, lbu, lh, lhu} = 4'b0000;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      #12;
      checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL reset_ld_ready got=%b exp=1", ld_ready); end
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
      checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
      checks++; if (load_data !== 32'h0) begin failures++; $display("FAIL reset_load_data got=%h exp=0", load_data); end
      checks++; if (load_valid !== 1'b0) begin failures++; $display("FAIL reset_load_valid got=%b exp=0", load_valid); end
      checks++; if (load_fault !== 1'b0) begin failures++; $display("FAIL reset_load_fault got=%b exp=0", load_fault); end
      @(negedge clk);
      reset = 1'b0;
      tick;
   endtask

   // gnt and rvalid together in the first REQ cycle: result two cycles after acceptance.
   task automatic run_fast(input string name, input logic [31:0] a, input logic [3:0] sel,
                           input logic [31:0] rdata, input logic [31:0] exp);
      request(a, sel);
      tick;
      drop_request;
      checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL %s mem_req got=%b exp=1", name, mem_req); end
      checks++; if (mem_addr !== {a[31:2], 2'b00}) begin failures++; $display("FAIL %s mem_addr got=%h exp=%h", name, mem_addr, {a[31:2], 2'b00}); end
      checks++; if (load_valid !== 1'b0) begin failures++; $display("FAIL %s early_valid got=%b exp=0", name, load_valid); end
      mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = rdata;
      tick;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h5A5A_5A5A;
      checks++; if (load_valid !== 1'b1) begin failures++; $display("FAIL %s load_valid got=%b exp=1", name, load_valid); end
      checks++; if (load_data !== exp) begin failures++; $display("FAIL %s load_data got=%h exp=%h", name, load_data, exp); end
      checks++; if (load_fault !== 1'b0) begin failures++; $display("FAIL %s load_fault got=%b exp=0", name, load_fault); end
      tick;
      checks++; if (load_valid !== 1'b0) begin failures++; $display("FAIL %s pulse_end got=%b exp=0", name, load_valid); end
      checks++; if (load_data !== exp) begin failures++; $display("FAIL %s data_hold got=%h exp=%h", name, load_data, exp); end
      checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL %s ld_ready got=%b exp=1", name, ld_ready); end
   endtask

   task automatic test_lb_fast;
      run_fast("lb_103", 32'h0000_0103, 4'b1000, 32'h80FF_1234, 32'hFFFF_FF80);
   endtask

   task automatic test_extract;
      run_fast("lbu_102", 32'h0000_0102, 4'b0100, 32'h8001_7F00, 32'h0000_0001);
      run_fast("lhu_102", 32'h0000_0102, 4'b0001, 32'h8001_7F00, 32'h0000_8001);
      run_fast("lh_102",  32'h0000_0102, 4'b0010, 32'h8001_7F00, 32'hFFFF_8001);
      run_fast("lb_101",  32'h0000_0101, 4'b1000, 32'h8001_7F00, 32'h0000_007F);
      run_fast("lh_100",  32'h0000_0100, 4'b0010, 32'h1234_8ABC, 32'hFFFF_8ABC);
      run_fast("prio_lh_lhu",  32'h0000_0102, 4'b0011, 32'h8001_7F00, 32'hFFFF_8001);
      run_fast("prio_lbu_lh",  32'h0000_0102, 4'b0110, 32'h8001_7F00, 32'h0000_0001);
   endtask

   task automatic test_lw_delayed;
      request(32'h0000_0200, 4'b0000);
      tick;
      drop_request;
      for (int i = 0; i < 3; i++) begin
         checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL lw_req_hold[%0d] got=%b exp=1", i, mem_req); end
         checks++; if (mem_addr !== 32'h0000_0200) begin failures++; $display("FAIL lw_addr_hold[%0d] got=%h exp=00000200", i, mem_addr); end
         mem_rdata = 32'h1111_0000 + i;
         mem_rvalid = 1'b0;
         if (i == 2) mem_gnt = 1'b1;
         tick;
      end
      mem_gnt = 1'b0;
      for (int i = 0; i < 2; i++) begin
         checks++; if (mem_req !== 1'b0 || load_valid !== 1'b0) begin failures++; $display("FAIL lw_wait[%0d] req=%b valid=%b exp=0/0", i, mem_req, load_valid); end
         tick;
      end
      mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      tick;
      mem_rvalid = 1'b0; mem_rdata = 32'h0;
      checks++; if (load_valid !== 1'b1) begin failures++; $display("FAIL lw_valid got=%b exp=1", load_valid); end
      checks++; if (load_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL lw_data got=%h exp=deadbeef", load_data); end
      checks++; if (load_fault !== 1'b0) begin failures++; $display("FAIL lw_fault got=%b exp=0", load_fault); end
      tick;
      checks++; if (load_valid !== 1'b0) begin failures++; $display("FAIL lw_single_pulse got=%b exp=0", load_valid); end
   endtask

   task automatic run_misaligned(input string name, input logic [31:0] a, input logic [3:0] sel);
      request(a, sel);
      tick;
      drop_request;
      checks++; if (load_valid !== 1'b1) begin failures++; $display("FAIL %s valid got=%b exp=1", name, load_valid); end
      checks++; if (load_fault !== 1'b1) begin failures++; $display("FAIL %s fault got=%b exp=1", name, load_fault); end
      checks++; if (load_data !== 32'h0) begin failures++; $display("FAIL %s data got=%h exp=0", name, load_data); end
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL %s mem_req got=%b exp=0", name, mem_req); end
      tick;
      checks++; if (load_valid !== 1'b0 || mem_req !== 1'b0) begin failures++; $display("FAIL %s after valid=%b req=%b exp=0/0", name, load_valid, mem_req); end
      checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL %s ld_ready got=%b exp=1", name, ld_ready); end
   endtask

   task automatic test_misaligned;
      run_misaligned("mis_lh_101", 32'h0000_0101, 4'b0010);
      run_misaligned("mis_lw_202", 32'h0000_0202, 4'b0000);
   endtask

   task automatic test_timeout;
      request(32'h0000_0300, 4'b0000);
      tick;
      drop_request;
      mem_gnt = 1'b1;
      tick;
      mem_gnt = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++; if (load_valid !== 1'b0) begin failures++; $display("FAIL to_wait[%0d] valid got=%b exp=0", i, load_valid); end
         tick;
      end
      checks++; if (load_valid !== 1'b1) begin failures++; $display("FAIL to_valid got=%b exp=1", load_valid); end
      checks++; if (load_fault !== 1'b1) begin failures++; $display("FAIL to_fault got=%b exp=1", load_fault); end
      checks++; if (load_data !== 32'h0) begin failures++; $display("FAIL to_data got=%h exp=0", load_data); end
      mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
      tick;
      mem_rvalid = 1'b0;
      checks++; if (load_valid !== 1'b0) begin failures++; $display("FAIL late_rvalid valid got=%b exp=0", load_valid); end
      checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL late_rvalid ld_ready got=%b exp=1", ld_ready); end
      checks++; if (load_data !== 32'h0 || load_fault !== 1'b1) begin failures++; $display("FAIL late_rvalid hold data=%h fault=%b exp=0/1", load_data, load_fault); end
      run_fast("lw_after_to", 32'h0000_0204, 4'b0000, 32'hCAFE_F00D, 32'hCAFE_F00D);
   endtask

   task automatic test_reset_mid;
      request(32'h0000_0400, 4'b0000);
      tick;
      drop_request;
      mem_gnt = 1'b1;
      tick;
      mem_gnt = 1'b0;
      tick;
      reset = 1'b1;
      #1;
      checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL rst_mid ld_ready got=%b exp=1", ld_ready); end
      checks++; if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin failures++; $display("FAIL rst_mid mem req=%b addr=%h exp=0/0", mem_req, mem_addr); end
      checks++; if (load_data !== 32'h0 || load_valid !== 1'b0 || load_fault !== 1'b0) begin
         failures++; $display("FAIL rst_mid outputs data=%h valid=%b fault=%b exp=0/0/0", load_data, load_valid, load_fault);
      end
      #1;
      reset = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
      tick;
      mem_rvalid = 1'b0;
      checks++; if (load_valid !== 1'b0) begin failures++; $display("FAIL rst_mid stale_rvalid valid got=%b exp=0", load_valid); end
      tick;
      checks++; if (load_valid !== 1'b0 || ld_ready !== 1'b1) begin failures++; $display("FAIL rst_mid settle valid=%b ready=%b exp=0/1", load_valid, ld_ready); end
      checks++; if (load_data !== 32'h0) begin failures++; $display("FAIL rst_mid data got=%h exp=0", load_data); end
   endtask

   initial begin
      test_reset;
      test_lb_fast;
      test_extract;
      test_lw_delayed;
      test_misaligned;
      test_timeout;
      test_reset_mid;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
